seg7_scan_capture: RTL and testbench
====================================

// Module: seg7_scan_capture
// PURPOSE
//  Reader side of the multiplexed 4-digit 7-segment display bus: samples active-low segment lines and
//  active-high digit enables, decodes each stable digit back to a hex nibble plus dot, and assembles a
//  16-bit value. Used as an on-chip loopback checker for the display driver and to capture external displays.
// PARAMETERS
//  STABLE_CYCLES   16      consecutive identical synchronized samples before a digit is accepted (>=2)
//  TIMEOUT_CYCLES  2**20   idle cycles before a partial frame is discarded (SEG7_CAP_TIMEOUT_EN only)
// PORTS
//  CLK        in   1   system clock
//  RST_N      in   1   asynchronous active-low reset
//  seg_n      in   8   segment lines, active-low; [6:0] pattern (bit0=a..bit6=g), [7] decimal point
//  dig_en     in   4   digit enables, active-high; dig_en[i] selects nibble i (value[4i+3:4i])
//  value      out  16  last complete frame, nibble 3 most significant
//  dots       out  4   dot state per digit of last complete frame (1 = lit)
//  valid      out  1   one-cycle pulse when value/dots update
//  dec_err    out  1   one-cycle pulse: accepted sample had an undecodable pattern
//  sel_err    out  1   one-cycle pulse: accepted sample had more than one digit enable
//  stale      out  1   one-cycle pulse: partial frame discarded by timeout (0 when macro off)
// BEHAVIOUR
//  - Reset: value=16'h0000, dots=0, valid/dec_err/sel_err/stale=0, seen=0, shadow=0, stability counter=0, armed=1.
//  - Input path: seg_n and dig_en pass through a 2-flop synchronizer; all decisions use the synchronized copy.
//  - Stability: counter clears whenever {seg_n,dig_en} differs from previous cycle, else increments, saturating
//    at STABLE_CYCLES. Reaching STABLE_CYCLES with armed=1 = "accept"; accept clears armed; any change sets armed.
//    Exactly one accept per stable period, however long it lasts.
//  - On accept:  dig_en==0 -> blanking gap, no action, no error.
//                dig_en not one-hot -> sel_err pulse, no write.
//                one-hot, pattern undecodable -> dec_err pulse, seen bit untouched.
//                one-hot, decodable -> shadow[i]<=nibble, shadow_dot[i]<=~seg_n[7], seen[i]<=1.
//  - Re-accept of an already-seen digit overwrites its shadow nibble (latest wins).
//  - Frame complete: cycle after seen becomes 4'b1111, value<=shadow, dots<=shadow_dot, valid pulses,
//    seen<=0. Latency input edge -> valid = 2 (sync) + STABLE_CYCLES + 2 cycles for the final digit.
//  - Decode table (pattern[6:0] -> nibble): 1000000->0 1111001->1 0100100->2 0110000->3 0011001->4
//    0010010->5 0000010->6 1111000->7 0000000->8 0010000->9 0001000->A 1100000->B 0110001->C 1000010->D
//    0111000->F. Encoder maps both 3 and E to 0110000; decoder resolves to 3 (E never produced). All else undecodable.
//  - Reset mid-frame: all state cleared asynchronously; first frame after reset requires all four digits again.
// CONFIGURATION
//  SEG7_CAP_TIMEOUT_EN defined: idle counter clears on every accept, increments otherwise; at TIMEOUT_CYCLES
//    with seen!=0, seen<=0 and stale pulses once; seen==0 never times out.
//  Not defined: no idle counter, partial frames persist indefinitely, stale tied to 0.
// STRUCTURE
//  seg7_pkg: SEG_* 7-bit pattern localparams for 0-F, NUM_DIGITS=4, nibble/pattern typedefs; shared with
//    the display driver so encoder and decoder use one table.
//  Sub-module seg7_pattern_decode: combinational pattern[6:0] -> {ok, nibble[3:0]} from the package table.
//  Top: synchronizer, stability counter/armed flag, shadow+seen registers, frame commit, optional timeout.
// TESTING
//  1 Drive digits 0..3 one-hot with patterns 4,3,2,1, each held 40 cycles -> one valid pulse, value=16'h1234.
//  2 Hold digit 0 pattern 0110000 for STABLE_CYCLES-1 then change -> no accept; full frame later decodes it as 3.
//  3 dig_en=4'b0011 held 40 cycles -> single sel_err pulse, no valid, seen unchanged.
//  4 Pattern 7'b1111111 on digit 2 -> dec_err pulse; next good frame 'hABCD with dot on digit 1 -> value='hABCD, dots=4'b0010.
//  5 Assert RST_N low after 2 digits captured -> outputs zero; next complete frame still needs all 4 digits.
//  6 Macro on, TIMEOUT_CYCLES=64: capture 1 digit then idle 64 cycles -> stale pulse, later frame has no stale data.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment pattern table (bit0=a .. bit6=g, active-low) used by both the
// display driver and the scan-capture decoder.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg_pat_t;

    localparam seg_pat_t SEG_0 = 7'b1000000;
    localparam seg_pat_t SEG_1 = 7'b1111001;
    localparam seg_pat_t SEG_2 = 7'b0100100;
    localparam seg_pat_t SEG_3 = 7'b0110000;
    localparam seg_pat_t SEG_4 = 7'b0011001;
    localparam seg_pat_t SEG_5 = 7'b0010010;
    localparam seg_pat_t SEG_6 = 7'b0000010;
    localparam seg_pat_t SEG_7 = 7'b1111000;
    localparam seg_pat_t SEG_8 = 7'b0000000;
    localparam seg_pat_t SEG_9 = 7'b0010000;
    localparam seg_pat_t SEG_A = 7'b0001000;
    localparam seg_pat_t SEG_B = 7'b1100000;
    localparam seg_pat_t SEG_C = 7'b0110001;
    localparam seg_pat_t SEG_D = 7'b1000010;
    // The encoder shares the 3 glyph for E, so the decoder can never return E.
    localparam seg_pat_t SEG_E = SEG_3;
    localparam seg_pat_t SEG_F = 7'b0111000;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to hex-nibble decoder; ok_o low for any pattern
// outside the shared table.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  seg_pat_t pattern_i,
    output logic     ok_o,
    output nibble_t  nibble_o
);

    always_comb begin
        ok_o     = 1'b1;
        nibble_o = 4'h0;
        case (pattern_i)
            SEG_0:   nibble_o = 4'h0;
            SEG_1:   nibble_o = 4'h1;
            SEG_2:   nibble_o = 4'h2;
            SEG_3:   nibble_o = 4'h3;
            SEG_4:   nibble_o = 4'h4;
            SEG_5:   nibble_o = 4'h5;
            SEG_6:   nibble_o = 4'h6;
            SEG_7:   nibble_o = 4'h7;
            SEG_8:   nibble_o = 4'h8;
            SEG_9:   nibble_o = 4'h9;
            SEG_A:   nibble_o = 4'hA;
            SEG_B:   nibble_o = 4'hB;
            SEG_C:   nibble_o = 4'hC;
            SEG_D:   nibble_o = 4'hD;
            SEG_F:   nibble_o = 4'hF;
            default: ok_o     = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Multiplexed 7-segment bus reader: synchronize, debounce, decode, assemble frames.
// Optional partial-frame timeout enabled by defining SEG7_CAP_TIMEOUT_EN.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [7:0]  seg_n,
    input  logic [3:0]  dig_en,
    output logic [15:0] value,
    output logic [3:0]  dots,
    output logic        valid,
    output logic        dec_err,
    output logic        sel_err,
    output logic        stale
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [11:0]   sync1_q, sync2_q, prev_q;
    logic [CW-1:0] cnt_q;
    logic          armed_q;
    logic [15:0]   shadow_q;
    logic [3:0]    shadow_dot_q, seen_q, seen_d;

    logic [7:0]    seg_s;
    logic [3:0]    en_s;
    logic          changed, accept, write, commit, timeout_hit;
    logic [1:0]    idx;
    logic          dec_ok;
    nibble_t       dec_nib;

    assign seg_s   = sync2_q[11:4];
    assign en_s    = sync2_q[3:0];
    assign changed = (sync2_q != prev_q);
    // Accept fires on the cycle the counter reaches STABLE_CYCLES.
    assign accept  = armed_q && !changed && (cnt_q == CW'(STABLE_CYCLES - 1));
    assign write   = accept && $onehot(en_s) && dec_ok;
    assign commit  = (seen_q == 4'hF);

    seg7_pattern_decode u_decode (
        .pattern_i (seg_s[6:0]),
        .ok_o      (dec_ok),
        .nibble_o  (dec_nib)
    );

    always_comb begin
        idx = 2'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (en_s[i]) idx = 2'(i);
        end
    end

`ifdef SEG7_CAP_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    logic [IW-1:0] idle_q;

    assign timeout_hit = (idle_q == IW'(TIMEOUT_CYCLES)) && (seen_q != 4'h0) && !commit;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idle_q <= '0;
            stale  <= 1'b0;
        end else begin
            stale <= timeout_hit;
            if (accept) idle_q <= '0;
            else if (idle_q != IW'(TIMEOUT_CYCLES)) idle_q <= idle_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign stale       = 1'b0;
`endif

    always_comb begin
        seen_d = (commit || timeout_hit) ? 4'h0 : seen_q;
        if (write) seen_d[idx] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            prev_q       <= '0;
            cnt_q        <= '0;
            armed_q      <= 1'b1;
            shadow_q     <= '0;
            shadow_dot_q <= '0;
            seen_q       <= '0;
            value        <= '0;
            dots         <= '0;
            valid        <= 1'b0;
            dec_err      <= 1'b0;
            sel_err      <= 1'b0;
        end else begin
            sync1_q <= {seg_n, dig_en};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            valid   <= 1'b0;
            dec_err <= 1'b0;
            sel_err <= 1'b0;
            seen_q  <= seen_d;

            if (changed) begin
                cnt_q   <= '0;
                armed_q <= 1'b1;
            end else begin
                if (cnt_q != CW'(STABLE_CYCLES)) cnt_q <= cnt_q + 1'b1;
                if (accept) armed_q <= 1'b0;
            end

            if (accept && en_s != 4'h0) begin
                if (!$onehot(en_s)) sel_err <= 1'b1;
                else if (!dec_ok)   dec_err <= 1'b1;
            end

            if (write) begin
                shadow_q[{idx, 2'b00} +: 4] <= dec_nib;
                shadow_dot_q[idx]           <= ~seg_s[7];
            end

            if (commit) begin
                value <= shadow_q;
                dots  <= shadow_dot_q;
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture; the timeout scenario runs only when
// SEG7_CAP_TIMEOUT_EN is defined.
module tb_seg7_scan_capture;

`ifdef SEG7_CAP_TIMEOUT_EN
    localparam int TO = 64;
`else
    localparam int TO = 2**20;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  seg_n = 8'hFF;
    logic [3:0]  dig_en = 4'h0;
    logic [15:0] value;
    logic [3:0]  dots;
    logic        valid, dec_err, sel_err, stale;

    int n_vec = 0;
    int n_err = 0;
    int n_valid = 0, n_dec = 0, n_sel = 0, n_stale = 0;

    seg7_scan_capture #(.STABLE_CYCLES(16), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(clk), .RST_N(rst_n), .seg_n(seg_n), .dig_en(dig_en),
        .value(value), .dots(dots), .valid(valid),
        .dec_err(dec_err), .sel_err(sel_err), .stale(stale)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid)   n_valid++;
        if (dec_err) n_dec++;
        if (sel_err) n_sel++;
        if (stale)   n_stale++;
    end

    function automatic logic [6:0] pat(input logic [3:0] nib);
        case (nib)
            4'h0: pat = 7'b1000000;  4'h1: pat = 7'b1111001;
            4'h2: pat = 7'b0100100;  4'h3: pat = 7'b0110000;
            4'h4: pat = 7'b0011001;  4'h5: pat = 7'b0010010;
            4'h6: pat = 7'b0000010;  4'h7: pat = 7'b1111000;
            4'h8: pat = 7'b0000000;  4'h9: pat = 7'b0010000;
            4'hA: pat = 7'b0001000;  4'hB: pat = 7'b1100000;
            4'hC: pat = 7'b0110001;  4'hD: pat = 7'b1000010;
            4'hE: pat = 7'b0110000;  default: pat = 7'b0111000;
        endcase
    endfunction

    task automatic hold(input logic [3:0] en, input logic [7:0] sn, input int cyc);
        dig_en = en;
        seg_n  = sn;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic digit(input int i, input logic [3:0] nib, input bit dot, input int cyc);
        hold(4'(1 << i), {~dot, pat(nib)}, cyc);
    endtask

    task automatic blank(input int cyc);
        hold(4'h0, 8'hFF, cyc);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        n_vec++; if (value !== 16'h0000) begin n_err++; $display("FAIL reset_value got %h want 0000", value); end
        n_vec++; if (dots !== 4'h0)      begin n_err++; $display("FAIL reset_dots got %b want 0000", dots); end
        n_vec++; if (valid !== 1'b0)     begin n_err++; $display("FAIL reset_valid got %b want 0", valid); end
        n_vec++; if (dec_err !== 1'b0)   begin n_err++; $display("FAIL reset_dec_err got %b want 0", dec_err); end
        n_vec++; if (sel_err !== 1'b0)   begin n_err++; $display("FAIL reset_sel_err got %b want 0", sel_err); end
        n_vec++; if (stale !== 1'b0)     begin n_err++; $display("FAIL reset_stale got %b want 0", stale); end
        rst_n = 1'b1;
        blank(40);
    endtask

    task automatic test_basic_frame;
        int v0 = n_valid;
        digit(0, 4'h4, 0, 40);
        digit(1, 4'h3, 0, 40);
        digit(2, 4'h2, 0, 40);
        digit(3, 4'h1, 0, 40);
        blank(40);
        n_vec++; if (n_valid - v0 !== 1) begin n_err++; $display("FAIL basic_valid_pulses got %0d want 1", n_valid - v0); end
        n_vec++; if (value !== 16'h1234) begin n_err++; $display("FAIL basic_value got %h want 1234", value); end
        n_vec++; if (dots !== 4'h0)      begin n_err++; $display("FAIL basic_dots got %b want 0000", dots); end
    endtask

    task automatic test_short_hold;
        int v0 = n_valid;
        digit(0, 4'h9, 0, 15);
        blank(40);
        digit(1, 4'h8, 0, 40);
        digit(2, 4'h0, 0, 40);
        digit(3, 4'h5, 0, 40);
        blank(40);
        n_vec++; if (n_valid - v0 !== 0) begin n_err++; $display("FAIL short_no_frame got %0d want 0", n_valid - v0); end
        hold(4'b0001, 8'b1011_0000, 40);
        blank(40);
        n_vec++; if (n_valid - v0 !== 1) begin n_err++; $display("FAIL short_frame_valid got %0d want 1", n_valid - v0); end
        n_vec++; if (value !== 16'h5083) begin n_err++; $display("FAIL short_value got %h want 5083", value); end
    endtask

    task automatic test_sel_err;
        int v0 = n_valid;
        int s0 = n_sel;
        digit(0, 4'h1, 0, 40);
        digit(1, 4'h2, 0, 40);
        digit(2, 4'h3, 0, 40);
        hold(4'b0011, {1'b1, pat(4'h9)}, 40);
        blank(40);
        n_vec++; if (n_sel - s0 !== 1)   begin n_err++; $display("FAIL sel_err_pulses got %0d want 1", n_sel - s0); end
        n_vec++; if (n_valid - v0 !== 0) begin n_err++; $display("FAIL sel_no_valid got %0d want 0", n_valid - v0); end
        digit(3, 4'h4, 0, 40);
        blank(40);
        n_vec++; if (n_valid - v0 !== 1) begin n_err++; $display("FAIL sel_frame_valid got %0d want 1", n_valid - v0); end
        n_vec++; if (value !== 16'h4321) begin n_err++; $display("FAIL sel_value got %h want 4321", value); end
    endtask

    task automatic test_dec_err;
        int v0 = n_valid;
        int d0 = n_dec;
        hold(4'b0100, 8'hFF, 40);
        blank(40);
        n_vec++; if (n_dec - d0 !== 1)   begin n_err++; $display("FAIL dec_err_pulses got %0d want 1", n_dec - d0); end
        n_vec++; if (n_valid - v0 !== 0) begin n_err++; $display("FAIL dec_no_valid got %0d want 0", n_valid - v0); end
        digit(0, 4'hD, 0, 40);
        digit(1, 4'hC, 1, 40);
        digit(2, 4'hB, 0, 40);
        digit(3, 4'hA, 0, 40);
        blank(40);
        n_vec++; if (value !== 16'hABCD) begin n_err++; $display("FAIL dec_value got %h want abcd", value); end
        n_vec++; if (dots !== 4'b0010)   begin n_err++; $display("FAIL dec_dots got %b want 0010", dots); end
    endtask

    task automatic test_overwrite;
        int v0 = n_valid;
        digit(0, 4'h1, 0, 40);
        digit(0, 4'h2, 1, 40);
        digit(1, 4'hF, 0, 40);
        digit(2, 4'hC, 0, 40);
        digit(3, 4'h0, 0, 40);
        blank(40);
        n_vec++; if (n_valid - v0 !== 1) begin n_err++; $display("FAIL ovw_valid got %0d want 1", n_valid - v0); end
        n_vec++; if (value !== 16'h0CF2) begin n_err++; $display("FAIL ovw_value got %h want 0cf2", value); end
        n_vec++; if (dots !== 4'b0001)   begin n_err++; $display("FAIL ovw_dots got %b want 0001", dots); end
    endtask

    task automatic test_reset_mid_frame;
        int v0;
        digit(0, 4'h6, 0, 40);
        digit(1, 4'h7, 1, 40);
        rst_n = 1'b0;
        blank(3);
        n_vec++; if (value !== 16'h0000) begin n_err++; $display("FAIL mid_rst_value got %h want 0000", value); end
        n_vec++; if (dots !== 4'h0)      begin n_err++; $display("FAIL mid_rst_dots got %b want 0000", dots); end
        rst_n = 1'b1;
        v0 = n_valid;
        digit(2, 4'h9, 0, 40);
        digit(3, 4'hB, 0, 40);
        blank(40);
        n_vec++; if (n_valid - v0 !== 0) begin n_err++; $display("FAIL mid_rst_partial got %0d want 0", n_valid - v0); end
        digit(0, 4'h6, 0, 40);
        digit(1, 4'h7, 0, 40);
        blank(40);
        n_vec++; if (n_valid - v0 !== 1) begin n_err++; $display("FAIL mid_rst_frame got %0d want 1", n_valid - v0); end
        n_vec++; if (value !== 16'hB976) begin n_err++; $display("FAIL mid_rst_value2 got %h want b976", value); end
    endtask

`ifdef SEG7_CAP_TIMEOUT_EN
    task automatic test_timeout;
        int v0 = n_valid;
        int t0 = n_stale;
        blank(200);
        n_vec++; if (n_stale - t0 !== 0) begin n_err++; $display("FAIL to_idle_empty got %0d want 0", n_stale - t0); end
        digit(0, 4'hE, 0, 40);
        blank(150);
        n_vec++; if (n_stale - t0 !== 1) begin n_err++; $display("FAIL to_stale_pulses got %0d want 1", n_stale - t0); end
        digit(1, 4'h1, 0, 40);
        digit(2, 4'h2, 0, 40);
        digit(3, 4'h3, 0, 40);
        blank(30);
        n_vec++; if (n_valid - v0 !== 0) begin n_err++; $display("FAIL to_discarded got %0d want 0", n_valid - v0); end
        digit(0, 4'h5, 0, 40);
        blank(30);
        n_vec++; if (n_valid - v0 !== 1) begin n_err++; $display("FAIL to_frame_valid got %0d want 1", n_valid - v0); end
        n_vec++; if (value !== 16'h3215) begin n_err++; $display("FAIL to_value got %h want 3215", value); end
    endtask
`endif

    initial begin
        test_reset;
        test_basic_frame;
        test_short_hold;
        test_sel_err;
        test_dec_err;
        test_overwrite;
        test_reset_mid_frame;
`ifdef SEG7_CAP_TIMEOUT_EN
        test_timeout;
`else
        n_vec++; if (n_stale !== 0) begin n_err++; $display("FAIL stale_disabled got %0d want 0", n_stale); end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
